// File: rtl/up3_control_unit.sv
// up3_control_unit: fetch/decode/execute control FSM driving the up3 datapath strobes.
// Define UP3_SINGLE_STEP_EN to add a step input and an IDLE wait state before each instruction.
module up3_control_unit #(
   parameter logic [7:0] HALT_OP = 8'hFF,
   parameter int         STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
`ifdef UP3_SINGLE_STEP_EN
   input  logic               step,
`endif
   input  logic [7:0]         opcode,
   input  logic               ac_neg,
   output logic               store_mem,
   output logic               fetch,
   output logic               load_pc,
   output logic               incr_pc,
   output logic               load_iru,
   output logic               load_irl,
   output logic               load_ac,
   output logic               halted,
   output logic [STATE_W-1:0] state
);
   typedef enum logic [3:0] {
      F1   = 4'd0,
      F2   = 4'd1,
      F3   = 4'd2,
      F4   = 4'd3,
      DEC  = 4'd4,
      EX   = 4'd5,
      HALT = 4'd6
`ifdef UP3_SINGLE_STEP_EN
      , IDLE = 4'd7
`endif
   } st_t;

`ifdef UP3_SINGLE_STEP_EN
   localparam st_t START = IDLE;
   logic step_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) step_q <= 1'b0;
      else step_q <= step;
`else
   localparam st_t START = F1;
`endif

   st_t st;

   // Completed non-halt instructions return to START (F1, or IDLE when single-stepping)
   always_ff @(posedge clk or negedge reset)
      if (!reset) st <= START;
      else
         case (st)
            F1:   st <= F2;
            F2:   st <= F3;
            F3:   st <= F4;
            F4:   st <= DEC;
            DEC:  st <= EX;
            EX:   st <= (opcode == HALT_OP) ? HALT : START;
            HALT: st <= HALT;
`ifdef UP3_SINGLE_STEP_EN
            IDLE: st <= (step && !step_q) ? F1 : IDLE;
`endif
            default: st <= F1;
         endcase

   logic ex;

   always_comb begin
      ex        = (st == EX);
      fetch     = (st == F1) || (st == F2) || (st == F3) || (st == F4);
      load_iru  = (st == F2);
      load_irl  = (st == F4);
      incr_pc   = (st == F2) || (st == F4);
      load_ac   = ex && (opcode == 8'h00 || opcode == 8'h01 || opcode == 8'h02 || opcode == 8'h06);
      store_mem = ex && (opcode == 8'h03);
      load_pc   = ex && ((opcode == 8'h04) || (opcode == 8'h05 && ac_neg));
      halted    = (st == HALT);
      state     = STATE_W'(st);
   end
endmodule

// File: tb/tb_up3_control_unit.sv
// tb_up3_control_unit: vector table plus hand sequences, checked through an expected-value queue.
module tb_up3_control_unit;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       ac_neg = 1'b0;
   logic [7:0] opcode = 8'h00;
`ifdef UP3_SINGLE_STEP_EN
   logic       step = 1'b0;
   localparam logic [3:0] RST_ST = 4'd7;
   localparam logic [7:0] RST_OUT = 8'h00;
`else
   localparam logic [3:0] RST_ST = 4'd0;
   localparam logic [7:0] RST_OUT = 8'h40;
`endif
   logic       store_mem, fetch, load_pc, incr_pc, load_iru, load_irl, load_ac, halted;
   logic [3:0] state;
   logic [11:0] act;
   logic [11:0] sb[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   up3_control_unit dut (
      .clk(clk),
      .reset(reset),
`ifdef UP3_SINGLE_STEP_EN
      .step(step),
`endif
      .opcode(opcode),
      .ac_neg(ac_neg),
      .store_mem(store_mem),
      .fetch(fetch),
      .load_pc(load_pc),
      .incr_pc(incr_pc),
      .load_iru(load_iru),
      .load_irl(load_irl),
      .load_ac(load_ac),
      .halted(halted),
      .state(state)
   );

   // bit order: state, store_mem, fetch, load_pc, incr_pc, load_iru, load_irl, load_ac, halted
   assign act = {state, store_mem, fetch, load_pc, incr_pc, load_iru, load_irl, load_ac, halted};

   typedef struct {
      string      name;
      logic [7:0] op;
      logic       neg;
      logic [7:0] ex;
   } vec_t;

   vec_t v[11];

   task automatic cmp(input string tag);
      logic [11:0] e;
      e = sb.pop_front();
      checks++;
      if (act !== e) begin
         errors++;
         $display("FAIL %s: got state=%0d strobes=%b, expected state=%0d strobes=%b",
                  tag, act[11:8], act[7:0], e[11:8], e[7:0]);
      end
   endtask

   task automatic cyc(input string tag, input logic [7:0] op, input logic neg, input logic [11:0] e);
      opcode = op;
      ac_neg = neg;
      sb.push_back(e);
      @(negedge clk);
      cmp(tag);
      @(posedge clk);
      #1;
   endtask

   task automatic step_in();
`ifdef UP3_SINGLE_STEP_EN
      step = 1'b1;
      cyc("idle_step", opcode, ac_neg, {4'd7, 8'h00});
      step = 1'b0;
`endif
   endtask

   task automatic body6(input string tag, input logic [7:0] op, input logic neg, input logic [7:0] ex);
      cyc({tag, "_f1"}, op, neg, {4'd0, 8'h40});
      cyc({tag, "_f2"}, op, neg, {4'd1, 8'h58});
      cyc({tag, "_f3"}, op, neg, {4'd2, 8'h40});
      cyc({tag, "_f4"}, op, neg, {4'd3, 8'h54});
      cyc({tag, "_dec"}, op, neg, {4'd4, 8'h00});
      cyc({tag, "_ex"}, op, neg, {4'd5, ex});
   endtask

   task automatic run_instr(input string tag, input logic [7:0] op, input logic neg, input logic [7:0] ex);
      step_in();
      body6(tag, op, neg, ex);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      v[0]  = '{"add",       8'h00, 1'b0, 8'h02};
      v[1]  = '{"sub",       8'h01, 1'b1, 8'h02};
      v[2]  = '{"load",      8'h02, 1'b0, 8'h02};
      v[3]  = '{"loadi",     8'h06, 1'b0, 8'h02};
      v[4]  = '{"store",     8'h03, 1'b1, 8'h80};
      v[5]  = '{"jump",      8'h04, 1'b0, 8'h20};
      v[6]  = '{"jneg_taken",8'h05, 1'b1, 8'h20};
      v[7]  = '{"jneg_not",  8'h05, 1'b0, 8'h00};
      v[8]  = '{"nop_7a",    8'h7A, 1'b0, 8'h00};
      v[9]  = '{"nop_07",    8'h07, 1'b1, 8'h00};
      v[10] = '{"jump_neg",  8'h04, 1'b1, 8'h20};

      repeat (2) cyc("reset", 8'h00, 1'b0, {RST_ST, RST_OUT});
      reset = 1'b1;
      for (int i = 0; i < 11; i++) run_instr(v[i].name, v[i].op, v[i].neg, v[i].ex);

      // asynchronous reset while in F3
      step_in();
      cyc("mid_f1", 8'h00, 1'b0, {4'd0, 8'h40});
      cyc("mid_f2", 8'h00, 1'b0, {4'd1, 8'h58});
      sb.push_back({4'd2, 8'h40});
      @(negedge clk);
      cmp("mid_f3");
      #2 reset = 1'b0;
      #1;
      sb.push_back({RST_ST, RST_OUT});
      cmp("async_reset");
      @(posedge clk);
      #1;
      cyc("reset_hold", 8'h00, 1'b0, {RST_ST, RST_OUT});
      reset = 1'b1;
      run_instr("after_reset", 8'h00, 1'b0, 8'h02);

      // LOADI / STORE / HALT program
      run_instr("prog_loadi", 8'h06, 1'b0, 8'h02);
      run_instr("prog_store", 8'h03, 1'b0, 8'h80);
      run_instr("prog_halt", 8'hFF, 1'b0, 8'h00);
      repeat (21) cyc("halted", 8'($urandom), 1'($urandom), {4'd6, 8'h01});

`ifdef UP3_SINGLE_STEP_EN
      reset = 1'b0;
      cyc("reset2", 8'h00, 1'b0, {RST_ST, RST_OUT});
      reset = 1'b1;
      repeat (50) cyc("idle_wait", 8'h00, 1'b0, {4'd7, 8'h00});
      step = 1'b1;
      cyc("held_idle", 8'h00, 1'b0, {4'd7, 8'h00});
      body6("held", 8'h00, 1'b0, 8'h02);
      repeat (5) cyc("step_held", 8'h00, 1'b0, {4'd7, 8'h00});
      step = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
